// File: rtl/dec_rt_pkg.sv
// dec_rt_pkg: shared widths, port codes, head-flit field positions and the
// decoded-result struct for the mesh routing decoder (dec_rt).
package dec_rt_pkg;

    // Field MSBs (widths are value+1)
    localparam int UADDR = 10;   // unicast node ID  [10:0]
    localparam int MADDR = 55;   // multicast bitmap [55:0]
    localparam int PORTW = 2;    // port code        [2:0]
    localparam int NPORT = 5;

    // Output port codes; port_mask bit index equals the code
    localparam logic [PORTW:0] P_LOCAL = 3'd0;
    localparam logic [PORTW:0] P_NORTH = 3'd1;  // Y-1
    localparam logic [PORTW:0] P_EAST  = 3'd2;  // X+1
    localparam logic [PORTW:0] P_SOUTH = 3'd3;  // Y+1
    localparam logic [PORTW:0] P_WEST  = 3'd4;  // X-1

    // Head flit layout as seen by the input buffer splitter
    localparam int UM_TYPE  = 63;
    localparam int MDST_MSB = 62;
    localparam int MDST_LSB = 7;
    localparam int DST_MSB  = 17;
    localparam int DST_LSB  = 7;

    typedef struct packed {
        logic [PORTW:0] port;
        logic [NPORT-1:0] mask;
        logic [MADDR:0] addr1_rm;
        logic multab_en;
        logic err;
    } rt_res_t;

    function automatic logic [NPORT-1:0] port_onehot(input logic [PORTW:0] p);
        port_onehot = NPORT'(1) << p;
    endfunction

endpackage

// File: rtl/dec_rt_dir.sv
// rt_dir: combinational XY dimension-order direction for one destination.
//   id  : destination node ID (id = X*MESH_Y + Y)
//   dir : port code (Local/North/East/South/West) seen from router (X_POS,Y_POS)
module rt_dir
    import dec_rt_pkg::*;
#(
    parameter int X_POS  = 0,
    parameter int Y_POS  = 0,
    parameter int MESH_Y = 7
) (
    input  logic [UADDR:0] id,
    output logic [PORTW:0] dir
);

    localparam logic [UADDR:0] OWN_X = (UADDR+1)'(X_POS);
    localparam logic [UADDR:0] OWN_Y = (UADDR+1)'(Y_POS);
    localparam logic [UADDR:0] MY    = (UADDR+1)'(MESH_Y);

    logic [UADDR:0] dx;
    logic [UADDR:0] dy;

    // X is resolved fully before Y is considered.
    always_comb begin
        dx  = id / MY;
        dy  = id % MY;
        dir = P_LOCAL;
        if (dx > OWN_X)      dir = P_EAST;
        else if (dx < OWN_X) dir = P_WEST;
        else if (dy > OWN_Y) dir = P_SOUTH;
        else if (dy < OWN_Y) dir = P_NORTH;
    end

endmodule

// File: rtl/dec_rt.sv
// dec_rt: routing decoder for one router of the mesh NoC.
//   Inputs : clk, rst (async, active-high), vld_in, um_type (0 uni / 1 multi),
//            addr0 (unicast node ID), addr1 (multicast bitmap, bit i = node i)
//   Outputs: vld_out, port, port_mask, addr1_rm, multab_en, err -- all
//            registered one cycle after vld_in; held while vld_in is low.
module dec_rt
    import dec_rt_pkg::*;
#(
    parameter int X_POS  = 0,
    parameter int Y_POS  = 0,
    parameter int MESH_X = 8,
    parameter int MESH_Y = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic             um_type,
    input  logic [UADDR:0]   addr0,
    input  logic [MADDR:0]   addr1,
    output logic             vld_out,
    output logic [PORTW:0]   port,
    output logic [NPORT-1:0] port_mask,
    output logic [MADDR:0]   addr1_rm,
    output logic             multab_en,
    output logic             err
);

    localparam int             OWN_ID  = X_POS*MESH_Y + Y_POS;
    localparam logic [UADDR:0] N_NODES = (UADDR+1)'(MESH_X*MESH_Y);
    localparam logic [MADDR:0] OWN_BIT = (MADDR+1)'(1) << OWN_ID;

    logic [MADDR:0][PORTW:0] dir_m;
    logic [PORTW:0]          dir_u;
    logic [NPORT-1:0]        mc_mask;
    logic [PORTW:0]          mc_port;

    rt_res_t res_d, res_q;
    logic    vld_d, vld_q;

    // One direction decoder per bitmap bit (constant IDs fold away) plus
    // one for the unicast address.
    for (genvar i = 0; i <= MADDR; i++) begin : g_mdir
        rt_dir #(.X_POS(X_POS), .Y_POS(Y_POS), .MESH_Y(MESH_Y)) u_dir (
            .id  ((UADDR+1)'(i)),
            .dir (dir_m[i])
        );
    end

    rt_dir #(.X_POS(X_POS), .Y_POS(Y_POS), .MESH_Y(MESH_Y)) u_udir (
        .id  (addr0),
        .dir (dir_u)
    );

    // Multicast fan-out: union of per-destination ports. Scanning from the
    // top down leaves mc_port at the lowest-indexed destination; a local
    // delivery always takes precedence.
    always_comb begin
        mc_mask = '0;
        mc_port = P_LOCAL;
        for (int i = MADDR; i >= 0; i--) begin
            if (addr1[i]) begin
                mc_mask = mc_mask | port_onehot(dir_m[i]);
                mc_port = dir_m[i];
            end
        end
        if (addr1[OWN_ID]) mc_port = P_LOCAL;
    end

    always_comb begin
        vld_d = vld_in;
        res_d = res_q;
        if (vld_in) begin
            res_d = '0;
            if (!um_type) begin
                if (addr0 >= N_NODES) begin
                    res_d.err = 1'b1;
                end else begin
                    res_d.port = dir_u;
                    res_d.mask = port_onehot(dir_u);
                end
            end else if (addr1 == '0) begin
                res_d.err = 1'b1;
            end else begin
                res_d.port      = mc_port;
                res_d.mask      = mc_mask;
                res_d.addr1_rm  = addr1 & ~OWN_BIT;
                // more than one bit set <=> clearing the lowest leaves a bit
                res_d.multab_en = |(mc_mask & (mc_mask - NPORT'(1)));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
        end
    end

    assign vld_out   = vld_q;
    assign port      = res_q.port;
    assign port_mask = res_q.mask;
    assign addr1_rm  = res_q.addr1_rm;
    assign multab_en = res_q.multab_en;
    assign err       = res_q.err;

endmodule

// File: tb/tb_dec_rt.sv
// tb_dec_rt: directed vectors into two decoders, router (0,0) and router (3,3),
// sharing the data inputs but with separate valids. The driver pushes the
// hand-computed result into a per-DUT queue; monitors pop and compare.
module tb_dec_rt;
    import dec_rt_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld_a = 1'b0, vld_b = 1'b0;
    logic          um = 1'b0;
    logic [10:0]   a0 = '0;
    logic [55:0]   a1 = '0;

    logic          vo_a, vo_b;
    logic [2:0]    port_a, port_b;
    logic [4:0]    mask_a, mask_b;
    logic [55:0]   rm_a, rm_b;
    logic          mt_a, mt_b, err_a, err_b;

    rt_res_t q_a[$];
    rt_res_t q_b[$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dec_rt #(.X_POS(0), .Y_POS(0), .MESH_X(8), .MESH_Y(7)) dut_a (
        .clk(clk), .rst(rst), .vld_in(vld_a), .um_type(um), .addr0(a0), .addr1(a1),
        .vld_out(vo_a), .port(port_a), .port_mask(mask_a), .addr1_rm(rm_a),
        .multab_en(mt_a), .err(err_a)
    );

    dec_rt #(.X_POS(3), .Y_POS(3), .MESH_X(8), .MESH_Y(7)) dut_b (
        .clk(clk), .rst(rst), .vld_in(vld_b), .um_type(um), .addr0(a0), .addr1(a1),
        .vld_out(vo_b), .port(port_b), .port_mask(mask_b), .addr1_rm(rm_b),
        .multab_en(mt_b), .err(err_b)
    );

    function automatic rt_res_t act_a();
        act_a = '{port: port_a, mask: mask_a, addr1_rm: rm_a, multab_en: mt_a, err: err_a};
    endfunction

    function automatic rt_res_t act_b();
        act_b = '{port: port_b, mask: mask_b, addr1_rm: rm_b, multab_en: mt_b, err: err_b};
    endfunction

    task automatic check(input string name, input rt_res_t act, input rt_res_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got port=%0d mask=%b rm=%h mt=%b err=%b, want port=%0d mask=%b rm=%h mt=%b err=%b",
                     name, act.port, act.mask, act.addr1_rm, act.multab_en, act.err,
                     exp.port, exp.mask, exp.addr1_rm, exp.multab_en, exp.err);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic send(input bit to_b, input logic u, input logic [10:0] x0,
                        input logic [55:0] x1, input logic [2:0] p, input logic [4:0] m,
                        input logic [55:0] rm, input logic mt, input logic e);
        rt_res_t r;
        r = '{port: p, mask: m, addr1_rm: rm, multab_en: mt, err: e};
        @(negedge clk);
        um = u; a0 = x0; a1 = x1;
        vld_a = !to_b; vld_b = to_b;
        if (to_b) q_b.push_back(r);
        else      q_a.push_back(r);
    endtask

    task automatic idle();
        @(negedge clk);
        vld_a = 1'b0; vld_b = 1'b0;
    endtask

    // Monitors
    always @(posedge clk) begin
        #1;
        if (vo_a) begin
            if (q_a.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL mon_a: vld_out with no expected entry");
            end else check("mon_a", act_a(), q_a.pop_front());
        end
        if (vo_b) begin
            if (q_b.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL mon_b: vld_out with no expected entry");
            end else check("mon_b", act_b(), q_b.pop_front());
        end
    end

    initial begin
        // Reset state
        #2;
        check("reset_a", act_a(), '0);
        check_bit("reset_vld_a", vo_a, 1'b0);
        check("reset_b", act_b(), '0);
        @(negedge clk);
        rst = 1'b0;

        // Router (0,0); unused field carries garbage
        //      b  um  addr0   addr1                 port mask     rm                    mt  err
        send(0, 1, 11'h7FF, 56'h1,                   0, 5'b00001, 56'h0,                0, 0);
        send(0, 1, 11'h7FF, 56'h11,                  0, 5'b01001, 56'h10,               1, 0);
        send(0, 1, 11'h7FF, 56'h111,                 0, 5'b01101, 56'h110,              1, 0);
        send(0, 1, 11'h7FF, 56'h1100,                2, 5'b00100, 56'h1100,             0, 0);
        send(0, 1, 11'd3,   56'h10,                  3, 5'b01000, 56'h10,               0, 0);
        send(0, 1, 11'd3,   56'h0,                   0, 5'b00000, 56'h0,                0, 1);
        send(0, 0, 11'd5,   56'hFF,                  3, 5'b01000, 56'h0,                0, 0);
        send(0, 0, 11'd60,  56'hFF,                  0, 5'b00000, 56'h0,                0, 1);
        send(0, 0, 11'd56,  56'h0,                   0, 5'b00000, 56'h0,                0, 1);
        send(0, 0, 11'd55,  56'h0,                   2, 5'b00100, 56'h0,                0, 0);
        send(0, 0, 11'd0,   56'h3,                   0, 5'b00001, 56'h0,                0, 0);
        send(0, 0, 11'd12,  56'h0,                   2, 5'b00100, 56'h0,                0, 0);
        idle();
        // With vld_in low the last result must be held
        @(posedge clk); #2;
        check_bit("hold_vld_a", vo_a, 1'b0);
        check("hold_a", act_a(), '{port: 3'd2, mask: 5'b00100, addr1_rm: 56'h0, multab_en: 1'b0, err: 1'b0});

        // Router (3,3), own ID 24
        send(1, 0, 11'd24,  56'h0,                   0, 5'b00001, 56'h0,                0, 0);
        send(1, 0, 11'd21,  56'h0,                   1, 5'b00010, 56'h0,                0, 0);
        send(1, 0, 11'd10,  56'h0,                   4, 5'b10000, 56'h0,                0, 0);
        send(1, 0, 11'd28,  56'h0,                   2, 5'b00100, 56'h0,                0, 0);
        send(1, 0, 11'd27,  56'h0,                   3, 5'b01000, 56'h0,                0, 0);
        send(1, 1, 11'd24,  56'h200400,              4, 5'b10010, 56'h200400,           1, 0);
        send(1, 1, 11'd0,   56'h80_0000_0100_0000,   0, 5'b00101, 56'h80_0000_0000_0000, 1, 0);
        idle();
        repeat (2) @(negedge clk);

        // Reset asserted between edges while outputs are valid and nonzero
        send(0, 0, 11'd5,   56'h0,                   3, 5'b01000, 56'h0,                0, 0);
        idle();
        #2 rst = 1'b1;
        #1;
        check_bit("midrst_vld_a", vo_a, 1'b0);
        check("midrst_a", act_a(), '0);
        check("midrst_b", act_b(), '0);
        @(negedge clk);
        rst = 1'b0;
        send(0, 0, 11'd12,  56'h0,                   2, 5'b00100, 56'h0,                0, 0);
        idle();

        // Drain, bounded
        for (int k = 0; k < 20 && (q_a.size() != 0 || q_b.size() != 0); k++) @(posedge clk);
        #2;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: %0d/%0d expected results never seen, want 0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
